// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    // Occupancy state of the multi-cycle mult/div unit.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Register $zero: a load targeting it never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default number of cycles the mult/div unit is busy after issue.
    localparam int MD_LATENCY_DEFAULT = 4;

    // Saturation ceiling of the stall-cycle counter.
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the mult/div unit: IDLE/BUSY FSM, latency countdown and a
// one-cycle done pulse marking the first cycle HI/LO are valid.
// mdIssue is a bare strobe (no ready): an issue while BUSY cannot be
// accepted and is dropped, because the front end stalls any mult/div
// sitting in ID until the unit is free.
module md_busy_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      mdIssue,
    output md_state_t mdState,
    output logic      mdBusy,
    output logic      mdDone
);

    localparam logic [CNT_W-1:0] LATENCY_CNT = CNT_W'(MD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_t        state;
    md_state_t        stateNext;
    logic [CNT_W-1:0] mdCnt;
    logic [CNT_W-1:0] cntNext;
    logic             doneNext;

    // State register: FSM state, countdown and done pulse, async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            mdCnt  <= '0;
            mdDone <= 1'b0;
        end else begin
            state  <= stateNext;
            mdCnt  <= cntNext;
            mdDone <= doneNext;
        end
    end

    // Next-state logic: load the latency on issue, count down while busy,
    // and return to idle with a done pulse on the last busy cycle.
    always_comb begin
        stateNext = state;
        cntNext   = mdCnt;
        doneNext  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (mdIssue) begin
                    stateNext = MD_BUSY;
                    cntNext   = LATENCY_CNT;
                end
            end
            MD_BUSY: begin
                if (mdCnt == CNT_ONE) begin
                    stateNext = MD_IDLE;
                    cntNext   = '0;
                    doneNext  = 1'b1;
                end else begin
                    cntNext = mdCnt - CNT_ONE;
                end
            end
            default: begin
                stateNext = MD_IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Output logic: busy is a pure decode of the registered state.
    always_comb begin
        mdBusy  = (state == MD_BUSY);
        mdState = state;
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Front-end hazard sequencer: merges load-use, mult/div occupancy and
// taken-branch redirect into PC / IF_ID / ID_EX controls, and counts
// stalled cycles for performance debug.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        if_id_is_md,
    input  logic        if_id_reads_hilo,
    input  logic        ex_md_issue,
    input  logic        branch_taken,
    input  logic        stat_clr,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        stall_mux,
    output logic        if_id_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    md_state_t mdState;
    logic      loadUse;
    logic      mdHazard;
    logic      stall;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_busy_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .mdIssue (ex_md_issue),
        .mdState (mdState),
        .mdBusy  (md_busy),
        .mdDone  (md_done)
    );

    // Hazard detection: a load feeding ID, or an HI/LO user while the unit is busy.
    always_comb begin
        loadUse  = id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
                   ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
        mdHazard = (mdState == MD_BUSY) && (if_id_is_md || if_id_reads_hilo);
        stall    = loadUse || mdHazard;
    end

    // Control priority: branch redirect beats stall, stall beats normal flow.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        stall_mux   = 1'b1;
        if_id_flush = 1'b0;
        if (branch_taken) begin
            if_id_flush = 1'b1;
            stall_mux   = 1'b0;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            stall_mux   = 1'b0;
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stat_clr) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != STAT_MAX)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with MD_LATENCY = 4.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        if_id_is_md;
    logic        if_id_reads_hilo;
    logic        ex_md_issue;
    logic        branch_taken;
    logic        stat_clr;
    logic        pc_write;
    logic        if_id_write;
    logic        stall_mux;
    logic        if_id_flush;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    pipeline_stall_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rt         (id_ex_rt),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .if_id_is_md      (if_id_is_md),
        .if_id_reads_hilo (if_id_reads_hilo),
        .ex_md_issue      (ex_md_issue),
        .branch_taken     (branch_taken),
        .stat_clr         (stat_clr),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .stall_mux        (stall_mux),
        .if_id_flush      (if_id_flush),
        .md_busy          (md_busy),
        .md_done          (md_done),
        .stall_cycles     (stall_cycles)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_ex_mem_read   = 1'b0;
        id_ex_rt         = 5'd0;
        if_id_rs         = 5'd0;
        if_id_rt         = 5'd0;
        if_id_is_md      = 1'b0;
        if_id_reads_hilo = 1'b0;
        ex_md_issue      = 1'b0;
        branch_taken     = 1'b0;
        stat_clr         = 1'b0;
    endtask

    // Raise an issue strobe; issuing into a busy unit is illegal.
    task automatic issue_md();
        check("issue_while_busy", {15'd0, md_busy}, 16'd0);
        ex_md_issue = 1'b1;
    endtask

    task automatic load_use_5();
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd5;
        if_id_rs       = 5'd5;
    endtask

    initial begin
        // ---- reset state ----
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("rst_pc_write",  {15'd0, pc_write},    16'd1);
        check("rst_stall_mux", {15'd0, stall_mux},   16'd1);
        check("rst_flush",     {15'd0, if_id_flush}, 16'd0);
        check("rst_md_busy",   {15'd0, md_busy},     16'd0);
        check("rst_md_done",   {15'd0, md_done},     16'd0);
        check("rst_stall_cnt", stall_cycles,         16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- load-use via rs ----
        load_use_5();
        settle();
        check("lu_pc_write",    {15'd0, pc_write},    16'd0);
        check("lu_if_id_write", {15'd0, if_id_write}, 16'd0);
        check("lu_stall_mux",   {15'd0, stall_mux},   16'd0);
        tick();
        check("lu_stall_cnt", stall_cycles, 16'd1);
        id_ex_mem_read = 1'b0;          // bubble reaches EX
        settle();
        check("lu_release_pc", {15'd0, pc_write}, 16'd1);
        tick();
        check("lu_cnt_hold", stall_cycles, 16'd1);

        // ---- load-use via rt ----
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd7;
        if_id_rs       = 5'd3;
        if_id_rt       = 5'd7;
        settle();
        check("lu_rt_pc_write", {15'd0, pc_write}, 16'd0);
        tick();
        check("lu_rt_cnt", stall_cycles, 16'd2);
        clear_inputs();

        // ---- load to $zero never stalls ----
        id_ex_mem_read = 1'b1;
        settle();
        check("zero_pc_write",  {15'd0, pc_write},  16'd1);
        check("zero_stall_mux", {15'd0, stall_mux}, 16'd1);
        tick();
        check("zero_cnt", stall_cycles, 16'd2);
        clear_inputs();

        // ---- stat_clr ----
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clr_cnt", stall_cycles, 16'd0);

        // ---- mult then mfhi ----
        if_id_reads_hilo = 1'b1;
        issue_md();
        settle();
        check("md_c0_pc_write", {15'd0, pc_write}, 16'd1);
        tick();
        ex_md_issue = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check($sformatf("md_c%0d_busy", c),  {15'd0, md_busy},  16'd1);
            check($sformatf("md_c%0d_pc", c),    {15'd0, pc_write}, 16'd0);
            check($sformatf("md_c%0d_done", c),  {15'd0, md_done},  16'd0);
            tick();
        end
        check("md_c5_busy", {15'd0, md_busy},  16'd0);
        check("md_c5_done", {15'd0, md_done},  16'd1);
        check("md_c5_pc",   {15'd0, pc_write}, 16'd1);
        check("md_c5_cnt",  stall_cycles,      16'd4);
        if_id_reads_hilo = 1'b0;
        tick();
        check("md_c6_done", {15'd0, md_done}, 16'd0);

        // ---- back-to-back div ----
        if_id_is_md = 1'b1;
        issue_md();
        tick();
        ex_md_issue = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check($sformatf("b2b_c%0d_pc", c), {15'd0, pc_write}, 16'd0);
            tick();
        end
        check("b2b_c5_done", {15'd0, md_done},  16'd1);
        check("b2b_c5_pc",   {15'd0, pc_write}, 16'd1);
        check("b2b_c5_cnt",  stall_cycles,      16'd8);
        if_id_is_md = 1'b0;
        issue_md();                     // second div enters EX on the done cycle
        tick();
        ex_md_issue = 1'b0;
        check("b2b_c6_busy", {15'd0, md_busy}, 16'd1);
        check("b2b_c6_done", {15'd0, md_done}, 16'd0);
        check("b2b_c6_pc",   {15'd0, pc_write}, 16'd1);
        repeat (4) tick();
        check("b2b_c10_busy", {15'd0, md_busy}, 16'd0);
        check("b2b_c10_done", {15'd0, md_done}, 16'd1);
        check("b2b_c10_cnt",  stall_cycles,     16'd8);
        tick();

        // ---- branch overrides a load-use stall ----
        load_use_5();
        branch_taken = 1'b1;
        settle();
        check("br_pc_write",    {15'd0, pc_write},    16'd1);
        check("br_if_id_write", {15'd0, if_id_write}, 16'd1);
        check("br_flush",       {15'd0, if_id_flush}, 16'd1);
        check("br_stall_mux",   {15'd0, stall_mux},   16'd0);
        tick();
        check("br_cnt", stall_cycles, 16'd8);
        clear_inputs();
        settle();
        check("br_flush_off", {15'd0, if_id_flush}, 16'd0);

        // ---- md hazard overlapping a load-use: one merged stall ----
        issue_md();
        tick();
        ex_md_issue      = 1'b0;
        if_id_reads_hilo = 1'b1;
        repeat (3) tick();
        load_use_5();                   // cycle 4: both hazards
        settle();
        check("mix_c4_pc", {15'd0, pc_write}, 16'd0);
        tick();
        check("mix_c5_done", {15'd0, md_done},  16'd1);
        check("mix_c5_pc",   {15'd0, pc_write}, 16'd0);
        tick();
        check("mix_c6_cnt", stall_cycles, 16'd13);
        clear_inputs();
        settle();
        check("mix_c6_pc", {15'd0, pc_write}, 16'd1);
        tick();

        // ---- reset while busy ----
        issue_md();
        tick();
        ex_md_issue = 1'b0;
        check("rb_busy_pre", {15'd0, md_busy}, 16'd1);
        rst_n = 1'b0;
        settle();
        check("rb_busy",     {15'd0, md_busy},   16'd0);
        check("rb_cnt",      stall_cycles,       16'd0);
        check("rb_done",     {15'd0, md_done},   16'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("rb_post%0d_done", c), {15'd0, md_done}, 16'd0);
        end
        check("rb_post_busy",  {15'd0, md_busy},   16'd0);
        check("rb_post_pc",    {15'd0, pc_write},  16'd1);
        check("rb_post_smux",  {15'd0, stall_mux}, 16'd1);

        // ---- saturation ----
        load_use_5();
        repeat (65540) @(posedge clk);
        #1;
        check("sat_cnt", stall_cycles, 16'hFFFF);
        tick();
        check("sat_hold", stall_cycles, 16'hFFFF);
        stat_clr = 1'b1;                // clear beats increment
        tick();
        check("sat_clr", stall_cycles, 16'd0);
        clear_inputs();
        tick();
        check("sat_after_clr", stall_cycles, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
